// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus plus UART FIFO handshakes between the memory controller/UART side
// (master) and mem_io_responder (slave).
interface mem_io_responder_if;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_end;

  modport master (
    output rdy_in, cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
    input  cpu_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_end
  );

  modport slave (
    input  rdy_in, cpu_a, cpu_wr, cpu_dout, tx_ready, rx_data, rx_valid,
    output cpu_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_end
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART window (TX FIFO, RX holding register) with 1-cycle reads.
// Optional: define MEM_IO_CYCLE_COUNTER_EN for a readable 32-bit cycle counter at 0x30008..0x3000B.
module mem_io_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus
);
  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [17:0] IO_RX   = 18'h30000;
  localparam logic [17:0] IO_STAT = 18'h30004;
`ifdef MEM_IO_CYCLE_COUNTER_EN
  localparam logic [17:0] IO_CYC0 = 18'h30008;
  localparam logic [17:0] IO_CYC1 = 18'h30009;
  localparam logic [17:0] IO_CYC2 = 18'h3000A;
  localparam logic [17:0] IO_CYC3 = 18'h3000B;
`endif

  logic [17:0] io_addr;
  logic        is_io, rd_en, wr_en;
  logic        unused_addr_bits;

  assign io_addr          = bus.cpu_a[17:0];
  assign is_io            = (io_addr[17:16] == 2'b11);
  assign rd_en            = bus.rdy_in & ~bus.cpu_wr;
  assign wr_en            = bus.rdy_in & bus.cpu_wr;
  assign unused_addr_bits = ^bus.cpu_a[31:18];

  // RAM with registered read port
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [7:0] ram_rd_q;

  // NOTE: storage arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en && !is_io) mem[bus.cpu_a[ADDR_WIDTH-1:0]] <= bus.cpu_dout;
    if (rd_en && !is_io) ram_rd_q <= mem[bus.cpu_a[ADDR_WIDTH-1:0]];
  end

  // TX FIFO
  logic [7:0]       tx_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_push_req, tx_push, tx_pop;
  logic             overflow_q, io_full_q;

  assign tx_push_req = wr_en && (io_addr == IO_RX);
  assign tx_pop      = (count_q != '0) && bus.tx_ready;
  assign tx_push     = tx_push_req && ((count_q != CNT_W'(TX_FIFO_DEPTH)) || tx_pop);

  always_comb begin
    count_d = count_q;
    if (tx_push && !tx_pop)      count_d = count_q + 1'b1;
    else if (!tx_push && tx_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[wr_ptr_q] <= bus.cpu_dout;
  end

  // RX holding register
  logic       rx_full_q;
  logic [7:0] rx_byte_q;
  logic       rx_capture, rx_pop;

  assign rx_capture = bus.rx_valid && !rx_full_q;
  assign rx_pop     = rd_en && (io_addr == IO_RX) && rx_full_q;

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, snap_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      if (bus.rdy_in) cyc_q <= cyc_q + 32'd1;
      // Snapshot on the low-byte read so the upper bytes match it.
      if (rd_en && (io_addr == IO_CYC0)) snap_q <= cyc_q;
    end
  end
`endif

  // IO read data, selected combinationally and registered below
  logic [7:0] io_rd_d, io_rd_q;
  logic       sel_io_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    io_rd_d = 8'h00;
    case (io_addr)
      IO_RX:   io_rd_d = rx_full_q ? rx_byte_q : 8'h00;
      IO_STAT: io_rd_d = {6'b0, overflow_q, rx_full_q};
`ifdef MEM_IO_CYCLE_COUNTER_EN
      IO_CYC0: io_rd_d = cyc_q[7:0];
      IO_CYC1: io_rd_d = snap_q[15:8];
      IO_CYC2: io_rd_d = snap_q[23:16];
      IO_CYC3: io_rd_d = snap_q[31:24];
`endif
      default: io_rd_d = 8'h00;
    endcase
  end

  logic program_end_q;

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      io_full_q     <= 1'b0;
      rx_full_q     <= 1'b0;
      rx_byte_q     <= 8'h00;
      sel_io_q      <= 1'b1;
      io_rd_q       <= 8'h00;
      program_end_q <= 1'b0;
    end else begin
      if (tx_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      io_full_q <= (count_d >= CNT_W'(TX_FIFO_DEPTH - FULL_MARGIN));
      if (tx_push_req && !tx_push) overflow_q <= 1'b1;

      if (rx_capture) begin
        rx_full_q <= 1'b1;
        rx_byte_q <= bus.rx_data;
      end else if (rx_pop) begin
        rx_full_q <= 1'b0;
      end

      if (rd_en) begin
        sel_io_q <= is_io;
        if (is_io) io_rd_q <= io_rd_d;
      end

      program_end_q <= wr_en && (io_addr == IO_STAT);
    end
  end

  assign bus.cpu_din        = sel_io_q ? io_rd_q : ram_rd_q;
  assign bus.tx_valid       = (count_q != '0);
  assign bus.tx_data        = bus.tx_valid ? tx_mem[rd_ptr_q] : 8'h00;
  assign bus.io_buffer_full = io_full_q;
  assign bus.rx_ready       = ~rx_full_q;
  assign bus.program_end    = program_end_q;
endmodule
